// File: rtl/insn_encoder_pkg.sv
// Shared RV32I definitions: one-hot type-code bit positions, major opcodes,
// encoder FSM states and the signed-range helper used by the packer.
package rv32i_pkg;

    localparam int CODE_W = 10;

    // Bit positions inside the one-hot type code (same order as OPDecoder)
    localparam int BIT_JAL    = 0;
    localparam int BIT_JALR   = 1;
    localparam int BIT_LUI    = 2;
    localparam int BIT_AUIPC  = 3;
    localparam int BIT_BRANCH = 4;
    localparam int BIT_RALU   = 5;
    localparam int BIT_STORE  = 6;
    localparam int BIT_IALU   = 7;
    localparam int BIT_LOAD   = 8;
    localparam int BIT_CSR    = 9;

    localparam logic [CODE_W-1:0] CODE_JAL    = 10'b00_0000_0001;
    localparam logic [CODE_W-1:0] CODE_JALR   = 10'b00_0000_0010;
    localparam logic [CODE_W-1:0] CODE_LUI    = 10'b00_0000_0100;
    localparam logic [CODE_W-1:0] CODE_AUIPC  = 10'b00_0000_1000;
    localparam logic [CODE_W-1:0] CODE_BRANCH = 10'b00_0001_0000;
    localparam logic [CODE_W-1:0] CODE_RALU   = 10'b00_0010_0000;
    localparam logic [CODE_W-1:0] CODE_STORE  = 10'b00_0100_0000;
    localparam logic [CODE_W-1:0] CODE_IALU   = 10'b00_1000_0000;
    localparam logic [CODE_W-1:0] CODE_LOAD   = 10'b01_0000_0000;
    localparam logic [CODE_W-1:0] CODE_CSR    = 10'b10_0000_0000;

    // Major opcodes
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_EMIT2 = 2'd2
    } enc_state_e;

    // True when value is the sign extension of its low 'bits' bits, i.e.
    // bits [31:bits-1] are all zero or all one.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (bits - 1);
        return ((value & mask) == 32'd0) || ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Request/response stream between an instruction producer and the encoder.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and all payload stable until that edge, and ready may
// depend combinationally on the receiver's state but never on valid.
interface insn_encoder_if;
    import rv32i_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                in_li;
    logic [4:0]          in_rd;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic [2:0]          in_funct3;
    logic [6:0]          in_funct7;
    logic [31:0]         in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_insn;
    logic                out_err;
    logic                out_last;

    // Producer/consumer side (drives requests, accepts words)
    modport master (
        output in_valid, in_code, in_li, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_insn, out_err, out_last
    );

    // Encoder side
    modport slave (
        input  in_valid, in_code, in_li, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_insn, out_err, out_last
    );
endinterface

// File: rtl/insn_encoder_pack.sv
// Combinational RV32I packer: scatters fields and immediate into the ISA
// bit positions for the selected format and flags range/one-hot violations.
// For a code with several bits set the lowest set bit selects the format so
// the word is still a deterministic truncated packing.
module insn_pack
    import rv32i_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic [31:0]       insn_o,
    output logic              err_o
);

    logic range_err;

    // Format selection, field scatter and per-format range check
    always_comb begin
        insn_o    = 32'd0;
        range_err = 1'b0;
        if (code_i[BIT_JAL]) begin
            insn_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            range_err = imm_i[0] || !fits_signed(imm_i, 21);
        end else if (code_i[BIT_JALR]) begin
            insn_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JALR};
            range_err = !fits_signed(imm_i, 12);
        end else if (code_i[BIT_LUI]) begin
            insn_o    = {imm_i[31:12], rd_i, OP_LUI};
            range_err = (imm_i[11:0] != 12'd0);
        end else if (code_i[BIT_AUIPC]) begin
            insn_o    = {imm_i[31:12], rd_i, OP_AUIPC};
            range_err = (imm_i[11:0] != 12'd0);
        end else if (code_i[BIT_BRANCH]) begin
            insn_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], OP_BRANCH};
            range_err = imm_i[0] || !fits_signed(imm_i, 13);
        end else if (code_i[BIT_RALU]) begin
            insn_o    = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_RALU};
        end else if (code_i[BIT_STORE]) begin
            insn_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
            range_err = !fits_signed(imm_i, 12);
        end else if (code_i[BIT_IALU]) begin
            insn_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IALU};
            range_err = !fits_signed(imm_i, 12);
        end else if (code_i[BIT_LOAD]) begin
            insn_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            range_err = !fits_signed(imm_i, 12);
        end else if (code_i[BIT_CSR]) begin
            insn_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_CSR};
            range_err = !fits_signed(imm_i, 12);
        end
    end

    assign err_o = range_err || !$onehot(code_i);

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: accepts decoded fields over a valid/ready
// stream, emits packed words with a one-cycle registered latency and
// expands 'li' into ADDI or LUI(+ADDI).
module insn_encoder
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    insn_encoder_if.slave bus,
    output enc_state_e dbg_state_o
);

    enc_state_e  state_q;
    logic        out_valid_q;
    logic [31:0] out_insn_q;
    logic        out_err_q;
    logic        out_last_q;
    logic [31:0] pend_insn_q;

    logic [31:0] pk_insn;
    logic        pk_err;
    logic        li_short;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic [31:0] first_insn_d;
    logic        first_err_d;
    logic        first_last_d;
    logic [31:0] pend_insn_d;
    logic        accept;

    insn_pack u_pack (
        .code_i   (bus.in_code),
        .rd_i     (bus.in_rd),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .funct3_i (bus.in_funct3),
        .funct7_i (bus.in_funct7),
        .imm_i    (bus.in_imm),
        .insn_o   (pk_insn),
        .err_o    (pk_err)
    );

    // (imm + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when
    // imm[11] is set, so the upper part is imm[31:12] plus that bit.
    assign li_short = fits_signed(bus.in_imm, 12);
    assign li_hi    = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
    assign li_lo    = bus.in_imm[11:0];

    // Select the first word of the request and any queued ADDI follow-up
    always_comb begin
        first_insn_d = pk_insn;
        first_err_d  = pk_err;
        first_last_d = 1'b1;
        pend_insn_d  = {li_lo, bus.in_rd, 3'b000, bus.in_rd, OP_IALU};
        if (bus.in_li) begin
            first_err_d = 1'b0;
            if (li_short) begin
                first_insn_d = {li_lo, 5'd0, 3'b000, bus.in_rd, OP_IALU};
            end else begin
                first_insn_d = {li_hi, bus.in_rd, OP_LUI};
                first_last_d = (li_lo == 12'd0);
            end
        end
    end

    // A new request may enter when idle, or when the final word of the
    // current one is leaving this same cycle.
    assign bus.in_ready = rst_n && ((state_q == ST_IDLE) ||
                          (state_q == ST_EMIT && bus.out_ready && out_last_q));
    assign accept = bus.in_valid && bus.in_ready;

    // Control FSM with the registered output word and queued ADDI
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_insn_q  <= 32'd0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pend_insn_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_EMIT;
                        out_valid_q <= 1'b1;
                        out_insn_q  <= first_insn_d;
                        out_err_q   <= first_err_d;
                        out_last_q  <= first_last_d;
                        pend_insn_q <= pend_insn_d;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        if (!out_last_q) begin
                            state_q    <= ST_EMIT2;
                            out_insn_q <= pend_insn_q;
                            out_err_q  <= 1'b0;
                            out_last_q <= 1'b1;
                        end else if (accept) begin
                            out_insn_q  <= first_insn_d;
                            out_err_q   <= first_err_d;
                            out_last_q  <= first_last_d;
                            pend_insn_q <= pend_insn_d;
                        end else begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                ST_EMIT2: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_insn  = out_insn_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_last  = out_last_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: hand-encoded vectors for each format,
// li expansion, error flags, backpressure, back-to-back and reset mid-li.
module tb_insn_encoder;
    import rv32i_pkg::*;

    logic       clk;
    logic       rst_n;
    enc_state_e dbg_state;
    int         vec_cnt;
    int         miscompares;

    insn_encoder_if bus ();

    insn_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until accepted (bounded wait)
    task automatic send(input logic [9:0] code, input logic li, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        bus.in_code   = code;
        bus.in_li     = li;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_wait", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Check the presented word, then consume it
    task automatic expect_word(input string tag, input logic [31:0] insn,
                               input logic err, input logic last);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_insn"},  bus.out_insn, insn);
        check({tag, "_err"},   {31'd0, bus.out_err}, {31'd0, err});
        check({tag, "_last"},  {31'd0, bus.out_last}, {31'd0, last});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_cnt       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_li     = 1'b0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_insn", bus.out_insn, 32'd0);
        check("rst_err", {31'd0, bus.out_err}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addi x1,x0,5
        send(CODE_IALU, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_word("addi", 32'h0050_0093, 1'b0, 1'b1);
        check("addi_done", {31'd0, bus.out_valid}, 32'd0);

        // li x5,0x12345678 -> LUI + ADDI
        send(10'd0, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        expect_word("li2_lui", 32'h1234_52B7, 1'b0, 1'b0);
        expect_word("li2_addi", 32'h6782_8293, 1'b0, 1'b1);

        // li x5,0xFFF -> negative low part
        send(10'd0, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFF);
        expect_word("lineg_lui", 32'h0000_12B7, 1'b0, 1'b0);
        expect_word("lineg_addi", 32'hFFF2_8293, 1'b0, 1'b1);

        // li x3,-1 -> single ADDI; li x3,0x12345000 -> single LUI
        send(10'd0, 1'b1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        expect_word("lishort", 32'hFFF0_0193, 1'b0, 1'b1);
        send(10'd0, 1'b1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_word("lilui", 32'h1234_51B7, 1'b0, 1'b1);

        // jal x1,0x800
        send(CODE_JAL, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        expect_word("jal", 32'h0010_00EF, 1'b0, 1'b1);

        // sw x2,8(x1) ; add x3,x1,x2
        send(CODE_STORE, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word("sw", 32'h0020_A423, 1'b0, 1'b1);
        send(CODE_RALU, 1'b0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        expect_word("add", 32'h0020_81B3, 1'b0, 1'b1);

        // Error cases: odd branch offset, bad code, LUI low bits, I out of range
        send(CODE_BRANCH, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        expect_word("br_err", 32'h0000_0163, 1'b1, 1'b1);
        send(10'b00_0000_0011, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        check("badcode_err", {31'd0, bus.out_err}, 32'd1);
        expect_word("badcode", bus.out_insn, 1'b1, 1'b1);
        send(CODE_LUI, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
        expect_word("lui_err", 32'h0000_10B7, 1'b1, 1'b1);
        send(CODE_IALU, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        expect_word("ialu_err", 32'h8000_0093, 1'b1, 1'b1);

        // Backpressure during li: words hold, in_ready stays low
        send(10'd0, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_insn", bus.out_insn, 32'h1234_52B7);
            check("bp_hold_last", {31'd0, bus.out_last}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        expect_word("bp_lui", 32'h1234_52B7, 1'b0, 1'b0);
        check("bp_emit2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        expect_word("bp_addi", 32'h6782_8293, 1'b0, 1'b1);
        check("bp_done", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back single-word requests at one per cycle
        bus.out_ready = 1'b1;
        bus.in_code   = CODE_IALU;
        bus.in_li     = 1'b0;
        bus.in_rd     = 5'd1;
        bus.in_rs1    = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_imm    = 32'd5;
        bus.in_valid  = 1'b1;
        tick();
        check("b2b_first", bus.out_insn, 32'h0050_0093);
        check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_imm = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        check("b2b_second", bus.out_insn, 32'h0070_0093);
        check("b2b_second_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("b2b_drained", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Reset while EMIT holds the LUI: the ADDI must never appear
        send(10'd0, 1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
        check("rstli_lui", bus.out_insn, 32'h1234_52B7);
        rst_n = 1'b0;
        tick();
        check("rstli_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rstli_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstli_no_addi", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Instruction packer for the RV32I control path. It takes decoded instruction fields (one-hot type code, registers, funct fields, 32-bit immediate) and produces the 32-bit instruction word. It scatters the immediate into the ISA bit positions, doing the inverse of the immediate-extraction step. It range-checks the immediate and expands the `li` pseudo-instruction into LUI/ADDI. It feeds the boot/program loader and the self-test instruction generator over a valid/ready stream.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_code` in 10: one-hot type code. The same encoding the OPDecoder produces:
  - bit0 JAL, bit1 JALR, bit2 LUI, bit3 AUIPC, bit4 BRANCH, bit5 R-ALU.
  - bit6 STORE, bit7 I-ALU, bit8 LOAD, bit9 CSR.
- `in_li` in 1: pseudo `li rd, imm`. When set, `in_code`, `in_rs1`, `in_rs2`, `in_funct3` and `in_funct7` are ignored.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register fields.
- `in_funct3` in 3, `in_funct7` in 7: function fields.
- `in_imm` in 32: immediate, as a byte offset or value.
- `out_valid` out 1: word present.
- `out_ready` in 1: consumer accepts the word when `out_valid && out_ready`.
- `out_insn` out 32: packed instruction.
- `out_err` out 1: qualifies `out_insn`; this request failed its checks.
- `out_last` out 1: final word of the current request.

## Operation

**Opcodes.**
- JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, BRANCH 1100011.
- R-ALU 0110011, STORE 0100011, I-ALU 0010011, LOAD 0000011, CSR 1110011.

**Packing per code.** Unused fields are zero.
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd.
- I (JALR, I-ALU, LOAD): [31:20]=imm[11:0], rs1, funct3, rd.
- U (LUI, AUIPC): [31:12]=imm[31:12], rd.
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], rs1, rs2, funct3.
- S (STORE) and CSR: [31:25]=imm[11:5], [11:7]=imm[4:0], rs1, rs2, funct3.
- R: funct7, rs2, rs1, funct3, rd. `in_imm` is ignored.

**Error checks.** When any check fails, `out_err`=1 and `out_insn` still holds the truncated packing.
- `in_code` must be exactly one-hot.
- J: imm[0]=0 and imm sign-extends from bit 20.
- B: imm[0]=0 and imm sign-extends from bit 12.
- I, S, CSR: imm sign-extends from bit 11.
- U: imm[11:0]=0.

**li expansion.**
- If imm sign-extends from bit 11: one word, `ADDI rd,x0,imm`.
- Otherwise compute `hi=(imm+32'h800)>>12` (mod 2^32) and `lo=imm[11:0]`.
  - Emit `LUI rd,hi`.
  - If lo≠0, follow it with `ADDI rd,rd,lo`.
- li never sets `out_err`.

**FSM.**
- IDLE: wait for a request.
- On accept, go to EMIT.
- EMIT holds the output register.
- When the word is consumed:
  - If a second li word is pending, go to EMIT2 (the ADDI is loaded that same cycle).
  - Otherwise go to IDLE.
- EMIT2 returns to IDLE once its word is consumed.

## Timing
- **Reset.** State=IDLE; `out_valid`=0; `out_insn`=0; `out_err`=0; `out_last`=0; `in_ready`=0 during reset.
- **Latency.** 1 cycle: the word is registered on the accept edge, and `out_valid` is high in the next cycle.
- **`in_ready`** = (state==IDLE) || (state==EMIT && `out_ready` && `out_last`). This allows back-to-back single-word requests at 1 per cycle.
- **Output stability.** While `out_valid && !out_ready`, all `out_*` signals hold stable.
- **li throughput.** A two-word li occupies 2 output beats and blocks new requests until the second beat is consumed.
- **Reset mid-request.** Any pending word, including a queued ADDI, is dropped.

## Structure
- Shared package `rv32i_pkg` holds:
  - the one-hot code constants;
  - the opcode localparams;
  - the `fits_signed(value, bits)` function.
- One combinational sub-module, `insn_pack`, maps (code, fields, imm) to {insn, err*}.
- The top level holds the FSM, the output register and the li split.

## Test plan
- **ADDI.** I-ALU, rd=1, rs1=0, funct3=0, imm=5 → 0x00500093, `out_err`=0, `out_last`=1, one cycle after accept.
- **Two-word li.** `li x5,0x12345678` → 0x123452B7 (`out_last`=0), then 0x67828293 (`out_last`=1).
- **li with negative low part.** `li x5,0x00000FFF` → 0x000012B7, then 0xFFF28293.
- **JAL.** rd=1, imm=0x800 → 0x001000EF.
- **Branch error.** BRANCH with imm=3 → `out_err`=1.
- **Bad code.** `in_code`=10'b0000000011 → `out_err`=1.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles during a li: both words are delivered in order and unchanged, and `in_ready`=0 throughout.
- **Reset mid-li.** Assert `rst_n`=0 while EMIT holds the LUI → `out_valid`=0 next cycle and no ADDI is ever emitted.
